// File: rtl/shake_pkg.sv
// Shared types and constants for the SHAKE squeeze stage.
package shake_pkg;

  localparam int RATE_WORDS_128 = 42;
  localparam int RATE_WORDS_256 = 34;
  localparam int IDX_W          = 6;
  // The 168-byte SHAKE128 rate reaches byte address 164, which needs 8 bits.
  localparam int SHA3_ADDR_W    = 8;

  typedef enum logic [2:0] {
    IDLE, WAIT_PERM, READ, NEXT, PERM_GAP, DRAIN, FIN
  } sq_state_e;

  function automatic logic [IDX_W-1:0] rate_words(input logic mode);
    return mode ? IDX_W'(RATE_WORDS_256) : IDX_W'(RATE_WORDS_128);
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/shake_squeeze_stream_if.sv
// sha3 state-read bus plus the output word stream of the squeeze stage.
interface shake_squeeze_stream_if;
  import shake_pkg::*;

  logic                   sha3_ready;
  logic [31:0]            sha3_dout;
  logic [SHA3_ADDR_W-1:0] sha3_addr;
  logic                   sha3_next;
  logic [31:0]            dout;
  logic                   dout_valid;
  logic                   dout_ready;
  logic                   dout_last;

  modport master (input  sha3_ready, sha3_dout, dout_ready,
                  output sha3_addr, sha3_next, dout, dout_valid, dout_last);
  modport slave  (output sha3_ready, sha3_dout, dout_ready,
                  input  sha3_addr, sha3_next, dout, dout_valid, dout_last);
endinterface

// File: rtl/shake_skid_fifo.sv
// 2-entry 32-bit skid FIFO; head is the oldest word, pop must only occur when non-empty.
module shake_skid_fifo (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] din,
  output logic [1:0]  count,
  output logic [31:0] head
);
  logic [1:0][31:0] mem_q, mem_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;

  // Pointer/count update; push and pop in the same cycle leave count unchanged.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + 2'(push) - 2'(pop);
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];
endmodule

// File: rtl/shake_squeeze_stream.sv
// SHAKE squeeze stage: reads rate words from the sha3 state, streams them out,
// and requests further permutations until out_words words are delivered.
// Build option: SHAKE_SQUEEZE_BSWAP_EN byte-reverses dout for big-endian consumers.
module shake_squeeze_stream
  import shake_pkg::*;
#(
  parameter int OUT_CNT_W  = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic [OUT_CNT_W-1:0]  out_words,
  shake_squeeze_stream_if.master bus,
  output logic                  busy,
  output logic                  done
);
  sq_state_e              state_q, state_d;
  logic                   mode_q, mode_d;
  logic [OUT_CNT_W-1:0]   out_words_q, out_words_d;
  logic [OUT_CNT_W-1:0]   issued_q, issued_d;
  logic [OUT_CNT_W-1:0]   delivered_q, delivered_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   inflight_q, inflight_d;
  logic [SHA3_ADDR_W-1:0] addr_q, addr_d;
  logic                   next_q, next_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [1:0]  fifo_cnt, cnt_after;
  logic [31:0] fifo_head;
  logic        pop, credit, issue;

  shake_skid_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight_q),
    .pop   (pop),
    .din   (bus.sha3_dout),
    .count (fifo_cnt),
    .head  (fifo_head)
  );

  // A word leaving this cycle frees its slot, which keeps reads at one per cycle.
  always_comb begin
    pop       = (fifo_cnt != 2'd0) && bus.dout_ready;
    cnt_after = fifo_cnt - 2'(pop);
    credit    = (32'(cnt_after) + 32'(inflight_q)) < 32'(FIFO_DEPTH);
    issue     = (state_q == READ) && credit && (issued_q != out_words_q);
  end

  // Next-state and datapath control for the squeeze FSM.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    out_words_d = out_words_q;
    issued_d    = issued_q;
    delivered_d = pop ? delivered_q + OUT_CNT_W'(1) : delivered_q;
    idx_d       = idx_q;
    inflight_d  = issue;
    addr_d      = addr_q;
    next_d      = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        mode_d      = mode;
        out_words_d = out_words;
        issued_d    = '0;
        delivered_d = '0;
        idx_d       = '0;
        busy_d      = 1'b1;
        state_d     = (out_words == '0) ? FIN : WAIT_PERM;
      end
      WAIT_PERM: if (bus.sha3_ready) begin
        idx_d   = '0;
        state_d = READ;
      end
      READ: if (issue) begin
        addr_d   = {idx_q, 2'b00};
        idx_d    = idx_q + IDX_W'(1);
        issued_d = issued_q + OUT_CNT_W'(1);
        if (issued_q + OUT_CNT_W'(1) == out_words_q)  state_d = DRAIN;
        else if (idx_q == rate_words(mode_q) - IDX_W'(1)) state_d = NEXT;
      end
      // The permutation may only start once the last rate word is captured.
      NEXT: if (!inflight_q) begin
        next_d  = 1'b1;
        state_d = PERM_GAP;
      end
      // The core drops sha3_ready a cycle late, so skip one cycle before polling it.
      PERM_GAP: begin
        idx_d   = '0;
        state_d = WAIT_PERM;
      end
      DRAIN: if (cnt_after == 2'd0 && !inflight_q) state_d = FIN;
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // All FSM state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      out_words_q <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      idx_q       <= '0;
      inflight_q  <= 1'b0;
      addr_q      <= '0;
      next_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      out_words_q <= out_words_d;
      issued_q    <= issued_d;
      delivered_q <= delivered_d;
      idx_q       <= idx_d;
      inflight_q  <= inflight_d;
      addr_q      <= addr_d;
      next_q      <= next_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.sha3_addr  = issue ? {idx_q, 2'b00} : addr_q;
  assign bus.sha3_next  = next_q;
  assign bus.dout_valid = (fifo_cnt != 2'd0);
  assign bus.dout_last  = bus.dout_valid && (delivered_q == out_words_q - OUT_CNT_W'(1));
`ifdef SHAKE_SQUEEZE_BSWAP_EN
  assign bus.dout       = bswap32(fifo_head);
`else
  assign bus.dout       = fifo_head;
`endif
  assign busy           = busy_q;
  assign done           = done_q;
endmodule

// File: tb/tb_shake_squeeze_stream.sv
// Self-checking bench for shake_squeeze_stream: table-driven squeeze runs with a
// scoreboard of expected words, plus hand-written zero-length, byte-order and reset cases.
`timescale 1ns/1ps
module tb_shake_squeeze_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] out_words = '0;
  logic        busy, done;

  shake_squeeze_stream_if bus ();

  shake_squeeze_stream #(.OUT_CNT_W(16), .FIFO_DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .out_words (out_words),
    .bus       (bus.master),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // sha3 core model: 1-cycle read latency, busy for a few cycles after sha3_next.
  int   perm_cnt;
  logic const_data = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perm_cnt      <= 0;
      bus.sha3_dout <= '0;
    end else begin
      bus.sha3_dout <= const_data ? 32'h11223344 : {24'h0, bus.sha3_addr};
      if (bus.sha3_next)      perm_cnt <= 6;
      else if (perm_cnt != 0) perm_cnt <= perm_cnt - 1;
    end
  end
  assign bus.sha3_ready = (perm_cnt == 0);

  typedef struct { logic [31:0] w; logic last; } exp_t;
  typedef struct { bit m; int n; int rp; int nx; } vec_t;

  exp_t        q[$];
  int          n_cmp = 0, n_err = 0;
  int          rpat = 0, cyc = 0, nexts = 0, hs = 0;
  bit          done_seen = 0, prev_stall = 0, stopped;
  logic [31:0] prev_dout;
  logic [7:0]  addr_before;
  vec_t        vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [7:0] addr);
    logic [31:0] w;
    w = const_data ? 32'h11223344 : {24'h0, addr};
`ifdef SHAKE_SQUEEZE_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // One clock: drive after the edge, monitor and score on the falling edge.
  task automatic tick();
    @(posedge clk); #1;
    start = 1'b0;
    cyc++;
    case (rpat)
      0:       bus.dout_ready = 1'b1;
      1:       bus.dout_ready = (cyc % 2 == 0);
      default: bus.dout_ready = 1'($urandom_range(0, 1));
    endcase
    @(negedge clk);
    if (bus.sha3_next) nexts++;
    if (done) done_seen = 1;
    if (prev_stall) begin
      check("stall_valid_held", bus.dout_valid, 1);
      check("stall_data_held", bus.dout, prev_dout);
    end
    if (bus.dout_valid && bus.dout_ready) begin
      check("word_expected", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        check("dout", bus.dout, e.w);
        check("dout_last", bus.dout_last, e.last);
        hs++;
      end
    end
    prev_stall = bus.dout_valid && !bus.dout_ready;
    prev_dout  = bus.dout;
  endtask

  task automatic run_op(input bit m, input int n, input int rp, input int exp_next,
                        input int stop_after, output bit stop_hit);
    int rw, c;
    rw = m ? 34 : 42;
    rpat = rp; nexts = 0; hs = 0; done_seen = 0; c = 0;
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.w    = exp_word(8'(4 * (k % rw)));
      e.last = (k == n - 1);
      q.push_back(e);
    end
    mode = m; out_words = 16'(n); start = 1'b1;
    tick();
    check("busy_after_start", busy, 1);
    while (!done_seen && c < 3000 && !(stop_after != 0 && hs >= stop_after)) begin
      tick();
      c++;
    end
    stop_hit = (stop_after != 0) && (hs >= stop_after) && !done_seen;
    if (stop_after == 0) begin
      check("done_seen", done_seen, 1);
      check("queue_drained", q.size(), 0);
      check("busy_clear_at_done", busy, 0);
      check("next_pulses", nexts, exp_next);
    end
  endtask

  initial begin
    vecs[0] = '{0,  4, 0, 0};
    vecs[1] = '{1, 40, 0, 1};
    vecs[2] = '{0, 42, 1, 0};
    vecs[3] = '{0, 43, 2, 1};
    vecs[4] = '{1, 34, 0, 0};
    vecs[5] = '{1, 70, 2, 2};
    vecs[6] = '{0, 85, 1, 2};
    vecs[7] = '{0,  1, 0, 0};
    bus.dout_ready = 1'b1;

    // Reset state
    #3;
    check("rst_dout_valid", bus.dout_valid, 0);
    check("rst_dout", bus.dout, 0);
    check("rst_dout_last", bus.dout_last, 0);
    check("rst_addr", bus.sha3_addr, 0);
    check("rst_next", bus.sha3_next, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();

    foreach (vecs[i]) run_op(vecs[i].m, vecs[i].n, vecs[i].rp, vecs[i].nx, 0, stopped);

    // Zero-length request: busy one cycle, done two cycles after start, no reads.
    rpat = 0; tick();
    addr_before = bus.sha3_addr;
    mode = 1'b0; out_words = 16'd0; start = 1'b1;
    tick();
    check("zero_busy", busy, 1);
    check("zero_done_early", done, 0);
    tick();
    check("zero_done", done, 1);
    check("zero_busy_clear", busy, 0);
    tick();
    check("zero_done_pulse", done, 0);
    check("zero_addr_held", bus.sha3_addr, {24'h0, addr_before});
    check("zero_no_valid", bus.dout_valid, 0);

    // Byte order of the output word
    const_data = 1'b1;
    run_op(0, 3, 0, 0, 0, stopped);
    const_data = 1'b0;

    // Reset mid-stream after 10 of 50 words, then a fresh 3-word request.
    run_op(1, 50, 0, 0, 10, stopped);
    check("mid_reset_reached", stopped, 1);
    rst_n = 1'b0;
    #1;
    check("mr_dout_valid", bus.dout_valid, 0);
    check("mr_dout", bus.dout, 0);
    check("mr_dout_last", bus.dout_last, 0);
    check("mr_addr", bus.sha3_addr, 0);
    check("mr_next", bus.sha3_next, 0);
    check("mr_busy", busy, 0);
    check("mr_done", done, 0);
    q.delete();
    prev_stall = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    run_op(0, 3, 0, 0, 0, stopped);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
